marquee_rx: RTL and testbench
=============================

MARQUEE_RX -- requirements
Module: marquee_rx

Interface
REQ-001 The block SHALL have parameter MISS_LIMIT, default 2, the number of consecutive bad frames in LOCK that forces a return to HUNT (legal range 1..7).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, qualifying indata; words with in_valid=0 are ignored and do not advance any state.
REQ-005 The block SHALL have port indata, input, 6 bits, the marquee word stream: slot0=A|B, slot1=A&B, slot2=A^B (each zero-extended), slot3={A,B}.
REQ-006 The block SHALL have port dataA, output, 3 bits, the recovered A of the last completed frame.
REQ-007 The block SHALL have port dataB, output, 3 bits, the recovered B of the last completed frame.
REQ-008 The block SHALL have port out_valid, output, 1 bit, a one-cycle pulse per completed frame.
REQ-009 The block SHALL have port frame_err, output, 1 bit, valid with out_valid; 1 means the frame failed the consistency check.
REQ-010 The block SHALL have port locked, output, 1 bit, 1 while in LOCK.

Function
REQ-011 The block SHALL keep a 4-word window w0..w3 (oldest..newest) of accepted words, plus a fill count 0..4 in HUNT and a slot counter 0..3 in LOCK.
REQ-012 A frame SHALL be consistent iff w0[5:3]=w1[5:3]=w2[5:3]=0, A=w3[5:3], B=w3[2:0], w0[2:0]=A|B, w1[2:0]=A&B and w2[2:0]=A^B.
REQ-013 In HUNT, each accepted word SHALL shift into the window; once fill=4, the window SHALL be checked on every accepted word.
REQ-014 On a consistent window in HUNT, the block SHALL go to LOCK with slot=0 and miss count 0, and SHALL output that frame (out_valid=1, frame_err=0).
REQ-015 An inconsistent window in HUNT SHALL produce no output.
REQ-016 In LOCK, slot SHALL advance by one per accepted word and wrap 3->0; the frame SHALL be evaluated when slot=3 is accepted.
REQ-017 Each evaluated LOCK frame SHALL pulse out_valid and drive dataA/dataB from the slot3 word, with frame_err equal to NOT consistent.
REQ-018 A consistent frame SHALL clear the miss count; an inconsistent frame SHALL increment it.
REQ-019 When the miss count reaches MISS_LIMIT, the block SHALL return to HUNT with fill=0 on that same edge.
REQ-020 Outputs SHALL be registered: out_valid rises the cycle after the edge that accepted the completing word, and dataA/dataB hold their value until the next frame.
REQ-021 With in_valid=0 the block SHALL hold all state, and out_valid SHALL be 0.

Reset
REQ-022 rst_n=0 SHALL immediately force HUNT, fill=0, slot=0, miss=0, dataA=0, dataB=0, out_valid=0, frame_err=0, locked=0, including in the middle of a frame.
REQ-023 After reset the window SHALL be treated as empty, and stale words SHALL NOT contribute to a match.

Configuration
REQ-024 When macro MARQUEE_RX_ERRCNT_EN is defined, the block SHALL add output err_cnt, 8 bits, reset 0, counting frames with frame_err=1 and saturating at 255.
REQ-025 When MARQUEE_RX_ERRCNT_EN is not defined, port err_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 Reset, then words 07,01,06,2B (A=5, B=3) each with in_valid=1 -> out_valid pulse, dataA=5, dataB=3, frame_err=0, locked=1.
REQ-027 Lead-in garbage 3F,15 followed by the REQ-026 frame -> no output until the 2B word, then the same result as REQ-026.
REQ-028 Locked, then frame 07,01,07,2B -> frame_err=1 and locked=1; a second bad frame -> locked=0 (MISS_LIMIT=2); err_cnt=2 when MARQUEE_RX_ERRCNT_EN is defined.
REQ-029 Locked, then valid frame words separated by idle cycles (in_valid=0) -> the same result as with contiguous words, and no pulse during the idles.
REQ-030 Assert rst_n=0 after two words of a locked frame, release it, then send a full frame -> no partial output, and the full frame is decoded correctly from HUNT.

Source files
------------

// File: rtl/marquee_rx.sv
// marquee_rx: locks onto a 4-word marquee frame stream and recovers A/B per frame.
// Optional MARQUEE_RX_ERRCNT_EN adds a saturating 8-bit err_cnt output.
`default_nettype none

module marquee_rx #(
  parameter int MISS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [5:0] indata,
  output logic [2:0] dataA,
  output logic [2:0] dataB,
  output logic       out_valid,
  output logic       frame_err,
  output logic       locked
`ifdef MARQUEE_RX_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [2:0] MISS_MAX = 3'(MISS_LIMIT);

  state_t     state, state_nxt;
  logic [2:0] fill, fill_nxt;
  logic [1:0] slot, slot_nxt;
  logic [2:0] miss, miss_nxt;
  logic       emit, emit_err;

  // Only the three previous words are stored; the incoming word completes the window.
  logic [5:0] w1, w2, w3;

  logic [2:0] a, b;
  logic       cons;

  assign a = indata[5:3];
  assign b = indata[2:0];

  assign cons = (w1[5:3] == 3'd0) && (w2[5:3] == 3'd0) && (w3[5:3] == 3'd0) &&
                (w1[2:0] == (a | b)) && (w2[2:0] == (a & b)) && (w3[2:0] == (a ^ b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    slot_nxt  = slot;
    miss_nxt  = miss;
    emit      = 1'b0;
    emit_err  = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          fill_nxt = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
          if ((fill >= 3'd3) && cons) begin
            state_nxt = LOCK;
            slot_nxt  = 2'd0;
            miss_nxt  = 3'd0;
            emit      = 1'b1;
          end
        end
        LOCK: begin
          slot_nxt = slot + 2'd1;
          if (slot == 2'd3) begin
            emit     = 1'b1;
            emit_err = !cons;
            if (cons) begin
              miss_nxt = 3'd0;
            end else if (miss + 3'd1 >= MISS_MAX) begin
              state_nxt = HUNT;
              fill_nxt  = 3'd0;
              slot_nxt  = 2'd0;
              miss_nxt  = 3'd0;
            end else begin
              miss_nxt = miss + 3'd1;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill      <= 3'd0;
      slot      <= 2'd0;
      miss      <= 3'd0;
      w1        <= 6'd0;
      w2        <= 6'd0;
      w3        <= 6'd0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      dataA     <= 3'd0;
      dataB     <= 3'd0;
    end else begin
      fill      <= fill_nxt;
      slot      <= slot_nxt;
      miss      <= miss_nxt;
      out_valid <= emit;
      if (in_valid) begin
        w1 <= w2;
        w2 <= w3;
        w3 <= indata;
      end
      if (emit) begin
        dataA     <= a;
        dataB     <= b;
        frame_err <= emit_err;
      end
    end
  end

  assign locked = (state == LOCK);

`ifdef MARQUEE_RX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      err_cnt <= 8'd0;
    else if (emit && emit_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_marquee_rx.sv
// tb_marquee_rx: directed self-checking bench for marquee_rx.
`default_nettype none

module tb_marquee_rx;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] indata;
  logic [2:0] dataA;
  logic [2:0] dataB;
  logic       out_valid;
  logic       frame_err;
  logic       locked;
`ifdef MARQUEE_RX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  marquee_rx #(.MISS_LIMIT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .indata    (indata),
    .dataA     (dataA),
    .dataB     (dataB),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .locked    (locked)
`ifdef MARQUEE_RX_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [5:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    indata   = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ov", {7'd0, out_valid}, 8'd0);
  endtask

  // Sends a 4-word frame; only the last word may produce the pulse.
  task automatic frame(input string tag, input logic [5:0] f0, input logic [5:0] f1,
                       input logic [5:0] f2, input logic [5:0] f3,
                       input logic exp_err, input logic exp_lock,
                       input logic [2:0] ea, input logic [2:0] eb);
    send(f0); check({tag, "_ov0"}, {7'd0, out_valid}, 8'd0);
    send(f1); check({tag, "_ov1"}, {7'd0, out_valid}, 8'd0);
    send(f2); check({tag, "_ov2"}, {7'd0, out_valid}, 8'd0);
    send(f3);
    check({tag, "_ov"},   {7'd0, out_valid}, 8'd1);
    check({tag, "_err"},  {7'd0, frame_err}, {7'd0, exp_err});
    check({tag, "_lock"}, {7'd0, locked},    {7'd0, exp_lock});
    check({tag, "_A"},    {5'd0, dataA},     {5'd0, ea});
    check({tag, "_B"},    {5'd0, dataB},     {5'd0, eb});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    indata   = 6'd0;
    #1;
    check("rst_ov",   {7'd0, out_valid}, 8'd0);
    check("rst_lock", {7'd0, locked},    8'd0);
    check("rst_A",    {5'd0, dataA},     8'd0);
    check("rst_B",    {5'd0, dataB},     8'd0);
    check("rst_err",  {7'd0, frame_err}, 8'd0);
    do_reset();

    // Basic acquisition: A=5, B=3.
    frame("acq", 6'h07, 6'h01, 6'h06, 6'h2B, 1'b0, 1'b1, 3'd5, 3'd3);
    idle();
    check("hold_A", {5'd0, dataA}, 8'd5);

    // Lead-in garbage before the frame.
    do_reset();
    send(6'h3F); check("lead0_ov", {7'd0, out_valid}, 8'd0);
    send(6'h15); check("lead1_ov", {7'd0, out_valid}, 8'd0);
    frame("lead", 6'h07, 6'h01, 6'h06, 6'h2B, 1'b0, 1'b1, 3'd5, 3'd3);

    // Idle-separated frame while locked: A=2, B=6.
    send(6'h06); idle();
    send(6'h02); idle();
    send(6'h04); check("gap_ov2", {7'd0, out_valid}, 8'd0); idle();
    send(6'h16);
    check("gap_ov",  {7'd0, out_valid}, 8'd1);
    check("gap_err", {7'd0, frame_err}, 8'd0);
    check("gap_A",   {5'd0, dataA},     8'd2);
    check("gap_B",   {5'd0, dataB},     8'd6);

    // Bad, good (clears miss), bad, bad -> unlock on the second consecutive miss.
    frame("bad1", 6'h07, 6'h01, 6'h07, 6'h2B, 1'b1, 1'b1, 3'd5, 3'd3);
    frame("good", 6'h07, 6'h01, 6'h06, 6'h2B, 1'b0, 1'b1, 3'd5, 3'd3);
    frame("bad2", 6'h07, 6'h01, 6'h07, 6'h2B, 1'b1, 1'b1, 3'd5, 3'd3);
    frame("bad3", 6'h07, 6'h01, 6'h07, 6'h2B, 1'b1, 1'b0, 3'd5, 3'd3);
`ifdef MARQUEE_RX_ERRCNT_EN
    check("err_cnt", err_cnt, 8'd3);
`endif

    // Zero-valued frame from HUNT: A=0, B=0 is consistent.
    frame("zero", 6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 1'b1, 3'd0, 3'd0);

    // Reset mid-frame, then reacquire.
    send(6'h07);
    send(6'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_lock", {7'd0, locked},    8'd0);
    check("mid_ov",   {7'd0, out_valid}, 8'd0);
    check("mid_A",    {5'd0, dataA},     8'd0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef MARQUEE_RX_ERRCNT_EN
    check("mid_cnt", err_cnt, 8'd0);
`endif
    frame("reacq", 6'h07, 6'h01, 6'h06, 6'h2B, 1'b0, 1'b1, 3'd5, 3'd3);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
